// File: rtl/cmd_issuer_pkg.sv
// Shared types for the command issuer and its scoreboard: entry layout, FSM states, constants.
// PROC_COUNT may be overridden from the build with `define PROC_COUNT (must be a power of 2).
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package cmd_issuer_pkg;
  localparam int PROC_COUNT = `PROC_COUNT;
  localparam int PROC_W     = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;
  localparam int CMD_ID_W   = 8;
  localparam int PAYLOAD_W  = 32;

  // Id 0 is reserved: empty scoreboard slot / command without dependency.
  localparam logic [CMD_ID_W-1:0] NO_DEP = '0;

  typedef struct packed {
    logic [CMD_ID_W-1:0] cmd_id;
    logic [PROC_W-1:0]   proc_id;
  } entry_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEP_REQ,
    ST_DEP_WAIT,
    ST_ALLOC,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DISPATCH,
    ST_FLUSH_REQ,
    ST_FLUSH_WAIT
  } state_t;
endpackage

// File: rtl/cmd_issuer_picker.sv
// Combinational priority encoder: index of the lowest set bit in a processor mask.
module lowest_free_picker
  import cmd_issuer_pkg::*;
(
  input  logic [PROC_COUNT-1:0] mask,
  output logic [PROC_W-1:0]     idx,
  output logic                  valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last one to write idx.
    for (int i = PROC_COUNT - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = PROC_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_issuer.sv
// In-order command issuer: dependency lookup, processor allocation, scoreboard insert/flush, dispatch.
// Optional ISSUER_STATS_EN adds saturating issue/stall counters.
module cmd_issuer
  import cmd_issuer_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [CMD_ID_W-1:0]   i_cmd_id,
  input  logic [CMD_ID_W-1:0]   i_dep_id,
  input  logic [PAYLOAD_W-1:0]  i_cmd_payload,
  output entry_t                o_sb_entry,
  output logic                  o_sb_read,
  output logic                  o_sb_write,
  output logic                  o_sb_flush,
  input  logic                  i_sb_ack,
  input  logic                  i_sb_exists,
  input  logic [PROC_W-1:0]     i_sb_id,
  output logic [PROC_COUNT-1:0] o_proc_start,
  output logic [CMD_ID_W-1:0]   o_proc_cmd_id,
  output logic [PAYLOAD_W-1:0]  o_proc_payload,
  input  logic [PROC_COUNT-1:0] i_proc_done,
  output logic [PROC_COUNT-1:0] o_busy
`ifdef ISSUER_STATS_EN
  ,
  output logic [31:0]           o_stat_issued,
  output logic [31:0]           o_stat_dep_stalls,
  output logic [31:0]           o_stat_alloc_stalls
`endif
);

  localparam logic [PROC_COUNT-1:0] ONE = PROC_COUNT'(1);

  state_t                state_reg, state_next;
  logic [PROC_COUNT-1:0] busy_reg, done_pend_reg;
  logic [CMD_ID_W-1:0]   proc_cmd_reg [PROC_COUNT];
  logic                  held_reg, retry_ok_reg;
  logic [CMD_ID_W-1:0]   cmd_id_reg, dep_id_reg;
  logic [PAYLOAD_W-1:0]  payload_reg;
  logic [PROC_W-1:0]     flush_idx_reg, alloc_idx_reg;

  logic [PROC_COUNT-1:0] pend_eff, free_mask, clr_mask;
  logic [PROC_W-1:0]     flush_pick, alloc_pick;
  logic                  flush_valid, alloc_valid;
  logic                  accept, latch_flush, latch_alloc;
  logic                  dep_stall, alloc_stall, flush_ack, dispatch;

  logic unused_sb_id;
  assign unused_sb_id = ^i_sb_id;

  // A done pulse arriving this cycle already counts, so flush beats a same-cycle accept.
  assign pend_eff  = done_pend_reg | (i_proc_done & busy_reg);
  assign free_mask = ~busy_reg & ~pend_eff;
  assign clr_mask  = flush_ack ? (ONE << flush_idx_reg) : '0;
  assign o_busy    = busy_reg;

  lowest_free_picker u_flush_pick (.mask(pend_eff),  .idx(flush_pick), .valid(flush_valid));
  lowest_free_picker u_alloc_pick (.mask(free_mask), .idx(alloc_pick), .valid(alloc_valid));

  always_comb begin
    state_next     = state_reg;
    o_cmd_ready    = 1'b0;
    o_sb_read      = 1'b0;
    o_sb_write     = 1'b0;
    o_sb_flush     = 1'b0;
    o_sb_entry     = '0;
    o_proc_start   = '0;
    o_proc_cmd_id  = '0;
    o_proc_payload = '0;
    accept         = 1'b0;
    latch_flush    = 1'b0;
    latch_alloc    = 1'b0;
    dep_stall      = 1'b0;
    alloc_stall    = 1'b0;
    flush_ack      = 1'b0;
    dispatch       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (flush_valid) begin
          latch_flush = 1'b1;
          state_next  = ST_FLUSH_REQ;
        end else if (held_reg) begin
          if (retry_ok_reg) state_next = ST_DEP_REQ;
        end else begin
          o_cmd_ready = i_rstn;
          if (i_cmd_valid) begin
            accept     = 1'b1;
            state_next = ST_DEP_REQ;
          end
        end
      end
      ST_DEP_REQ: begin
        if (dep_id_reg == NO_DEP) begin
          state_next = ST_ALLOC;
        end else begin
          o_sb_read  = 1'b1;
          o_sb_entry = '{cmd_id: dep_id_reg, proc_id: '0};
          state_next = ST_DEP_WAIT;
        end
      end
      ST_DEP_WAIT: begin
        o_sb_entry = '{cmd_id: dep_id_reg, proc_id: '0};
        if (i_sb_ack) begin
          if (i_sb_exists) begin
            dep_stall  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_ALLOC;
          end
        end
      end
      ST_ALLOC: begin
        if (alloc_valid) begin
          latch_alloc = 1'b1;
          state_next  = ST_WR_REQ;
        end else begin
          alloc_stall = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        o_sb_write = 1'b1;
        o_sb_entry = '{cmd_id: cmd_id_reg, proc_id: alloc_idx_reg};
        state_next = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        o_sb_entry = '{cmd_id: cmd_id_reg, proc_id: alloc_idx_reg};
        if (i_sb_ack) state_next = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        o_proc_start   = ONE << alloc_idx_reg;
        o_proc_cmd_id  = cmd_id_reg;
        o_proc_payload = payload_reg;
        dispatch       = 1'b1;
        state_next     = ST_IDLE;
      end
      ST_FLUSH_REQ: begin
        o_sb_flush = 1'b1;
        o_sb_entry = '{cmd_id: proc_cmd_reg[flush_idx_reg], proc_id: flush_idx_reg};
        state_next = ST_FLUSH_WAIT;
      end
      ST_FLUSH_WAIT: begin
        o_sb_entry = '{cmd_id: proc_cmd_reg[flush_idx_reg], proc_id: flush_idx_reg};
        if (i_sb_ack) begin
          flush_ack  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= '0;
      done_pend_reg <= '0;
      for (int i = 0; i < PROC_COUNT; i++) proc_cmd_reg[i] <= '0;
      held_reg      <= 1'b0;
      retry_ok_reg  <= 1'b0;
      cmd_id_reg    <= '0;
      dep_id_reg    <= '0;
      payload_reg   <= '0;
      flush_idx_reg <= '0;
      alloc_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      done_pend_reg <= (done_pend_reg | (i_proc_done & busy_reg)) & ~clr_mask;
      busy_reg      <= (busy_reg & ~clr_mask) | (dispatch ? (ONE << alloc_idx_reg) : '0);
      if (dispatch) proc_cmd_reg[alloc_idx_reg] <= cmd_id_reg;
      if (accept) begin
        held_reg    <= 1'b1;
        cmd_id_reg  <= i_cmd_id;
        dep_id_reg  <= i_dep_id;
        payload_reg <= i_cmd_payload;
      end else if (dispatch) begin
        held_reg    <= 1'b0;
      end
      // Retry of a stalled command waits for a processor to retire.
      if (dep_stall)      retry_ok_reg <= 1'b0;
      else if (flush_ack) retry_ok_reg <= 1'b1;
      if (latch_flush) flush_idx_reg <= flush_pick;
      if (latch_alloc) alloc_idx_reg <= alloc_pick;
    end
  end

`ifdef ISSUER_STATS_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stat_issued       <= '0;
      o_stat_dep_stalls   <= '0;
      o_stat_alloc_stalls <= '0;
    end else begin
      if (dispatch && (o_stat_issued != '1))          o_stat_issued       <= o_stat_issued + 32'd1;
      if (dep_stall && (o_stat_dep_stalls != '1))     o_stat_dep_stalls   <= o_stat_dep_stalls + 32'd1;
      if (alloc_stall && (o_stat_alloc_stalls != '1)) o_stat_alloc_stalls <= o_stat_alloc_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: doc/cmd_issuer.md
Name: cmd_issuer

Overview:
- In-order command issue stage that sits directly upstream of the scoreboard and owns its request port.
- Accepts commands from the command queue and queries the scoreboard to check whether each command's dependency is still executing.
- Picks a free processor, records the mapping {cmd_id, proc_id} in the scoreboard, then dispatches the command.
- On a processor's completion it flushes that processor's entry and frees the processor.

Parameters:
- PROC_COUNT, 4: number of processors; power of 2; equals `PROC_COUNT.
- CMD_ID_W, 8: command id width. Id 0 is reserved: "empty" for the scoreboard, "no dependency" for dep_id.
- PAYLOAD_W, 32: opaque command payload width.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command accepted when valid&ready.
- i_cmd_id  in  CMD_ID_W  id of the offered command; must be nonzero.
- i_dep_id  in  CMD_ID_W  id the command depends on; 0 = none.
- i_cmd_payload  in  PAYLOAD_W  command body.
- o_sb_entry  out  entry_t  {cmd_id, proc_id} presented to the scoreboard.
- o_sb_read  out  1  one-cycle lookup pulse.
- o_sb_write  out  1  one-cycle insert pulse.
- o_sb_flush  out  1  one-cycle remove pulse.
- i_sb_ack  in  1  scoreboard result valid (single-cycle).
- i_sb_exists  in  1  lookup/flush hit.
- i_sb_id  in  log2(PROC_COUNT)  proc id of hit (unused).
- o_proc_start  out  PROC_COUNT  one-hot dispatch pulse.
- o_proc_cmd_id  out  CMD_ID_W  id of dispatched command.
- o_proc_payload  out  PAYLOAD_W  payload of dispatched command.
- i_proc_done  in  PROC_COUNT  per-processor completion pulses.
- o_busy  out  PROC_COUNT  processor occupied bitmap.

Behaviour:
- Reset (async, any state): all outputs 0; o_cmd_ready=0; busy, done_pend, per-proc cmd_id registers and held command cleared; FSM=IDLE.
- Scoreboard protocol:
  - At most one request is outstanding.
  - Each request is a single-cycle pulse with o_sb_entry stable from the pulse until i_sb_ack.
  - No new pulse is issued in the cycle of or the cycle after an ack, because the scoreboard returns through OUT to IDLE.
- done_pend[p] is set on i_proc_done[p] and cleared when FLUSH_WAIT for p acks. Done pulses are never lost, including during an issue sequence.
- FSM:
  - IDLE:
    - If any done_pend bit is set, take the lowest index p, then FLUSH_REQ. Flush has priority over issue.
    - Else if a held command exists, go to DEP_REQ.
    - Else o_cmd_ready=1. On handshake, latch id/dep/payload and go to DEP_REQ.
  - DEP_REQ:
    - If dep_id==0, go straight to ALLOC.
    - Else pulse o_sb_read with entry.cmd_id=dep_id, then DEP_WAIT.
  - DEP_WAIT:
    - On ack with exists=1, the dependency is still running: keep the command held, go to IDLE, and retry only after at least one flush completes.
    - On ack with exists=0, go to ALLOC.
  - ALLOC:
    - If a free proc exists (~busy & ~done_pend), pick the lowest index q, then WR_REQ.
    - Else go to IDLE; the command stays held.
  - WR_REQ: pulse o_sb_write with entry={cmd_id,q}, then WR_WAIT.
  - WR_WAIT: on ack, go to DISPATCH.
  - DISPATCH (1 cycle):
    - o_proc_start[q]=1 with cmd_id and payload valid.
    - busy[q]<=1; proc_cmd[q]<=cmd_id; clear held command; go to IDLE.
  - FLUSH_REQ: pulse o_sb_flush with entry={proc_cmd[p],p}, then FLUSH_WAIT.
  - FLUSH_WAIT: on ack, busy[p]<=0, clear done_pend[p], set retry_ok, go to IDLE.
- Stall gating: retry_ok is cleared on each dependency stall. A held command re-enters DEP_REQ only when retry_ok=1. This prevents lookups spinning.
- Minimum latency for a command with no dependency: accept, then start pulse 4 cycles later plus the scoreboard write latency.
- i_proc_done on an idle (not busy) processor is ignored.
- Simultaneous done and cmd_valid in IDLE: the flush wins and o_cmd_ready=0 that cycle.
- A missing i_sb_ack hangs the FSM. This is accepted behaviour; no timeout.

Optional Feature:
- ISSUER_STATS_EN defined: adds three 32-bit saturating counters, o_stat_issued, o_stat_dep_stalls and o_stat_alloc_stalls, incremented on DISPATCH, on exists=1 in DEP_WAIT and on no-free in ALLOC. All are reset to 0.
- Undefined: the counters and their ports are absent; function is unchanged.

Decomposition:
- Shared package holds:
  - entry_t, as packed struct {cmd_id[CMD_ID_W], proc_id[log2 PROC_COUNT]}, shared with the scoreboard.
  - The FSM state enum.
  - The NO_DEP=0 constant.
- Sub-module: lowest_free_picker, a combinational priority encoder over a PROC_COUNT mask that outputs index and valid. It is used for both flush selection and allocation.

Test Plan:
- No dependency: cmd id=5, dep=0, all procs free -> write pulse with entry {5,0}; after ack, o_proc_start=0001 with cmd_id=5; o_busy=0001.
- Dependency hit:
  - Issue id=3 on proc0, then id=7 with dep=3 -> read pulse for 3, exists=1, no start.
  - i_proc_done[0] -> flush {3,0}, then read for 3 with exists=0 -> id=7 starts on proc0.
- All busy: 4 commands occupy procs 0..3; a fifth (id=9) holds with o_cmd_ready=0 -> done[2] gives flush {cmd,2}, then id 9 starts on proc2.
- Simultaneous events: done[1] and cmd_valid in the same IDLE cycle -> flush precedes accept; ready=0 that cycle. A done pulse arriving during WR_WAIT is not lost.
- Reset mid-operation: assert i_rstn=0 in WR_WAIT -> all outputs 0 immediately; after release, IDLE with o_cmd_ready=1 and o_busy=0.
- With ISSUER_STATS_EN: the sequence from the dependency-hit scenario -> issued=2, dep_stalls=1, alloc_stalls=0.
